aud_capture_ctrl: RTL and testbench
===================================

# aud_capture_ctrl

Sequencer for the audio sample buffer: arms on a host command, optionally waits for an amplitude trigger, writes a host-programmed number of mono samples into the sample BRAM on `advance` strobes, then serves them back one per Avalon DATA read. Sits between the Avalon slave decode and the audio driver / `bram` instance inside `audio_control`, replacing ad-hoc start/ram_e flag handling with an explicit FSM.

## Interface
- `SAMPLE_W`, 24, sample width (two's complement)
- `ADDR_W`, 11, BRAM address width
- `DEPTH`, 2048, BRAM words; must equal 2**`ADDR_W`

- `clk` in 1: single clock; everything is on its rising edge.
- `reset` in 1: synchronous, active-high.
- `advance` in 1: one-cycle strobe, new sample valid on `sample_in`.
- `sample_in` in `SAMPLE_W`: mono sample from the stereo-to-mono sum.
- `chipselect`, `write`, `read` in 1: Avalon slave controls.
- `address` in 16: word offset.
- `writedata` in 32: Avalon write data.
- `readdata` out 32: registered, valid the cycle after `read`.
- `ram_addr` out `ADDR_W`: BRAM address.
- `ram_we` out 1: BRAM write enable.
- `ram_din` out `SAMPLE_W`: BRAM write data.
- `ram_dout` in `SAMPLE_W`: BRAM read data, 1-cycle latency.
- `busy` out 1: high in ARMED, CAPTURE, DRAIN, READY.
- `done` out 1: sticky; set on readout completion, cleared by start or reset.

## Operation
- Register map (word offsets):
  - 0 CTRL (W): bit0 start, bit1 abort, bit2 trig_en.
  - 1 LENGTH (W): bits[`ADDR_W`:0]; 0 or >`DEPTH` clamps to `DEPTH`.
  - 2 THRESH (W): bits[`SAMPLE_W`-1:0], unsigned magnitude.
  - 3 STATUS (R): [2:0] state code, [3] done, [`ADDR_W`+16:16] current pointer.
  - 4 DATA (R): sample, sign-extended to 32.
  - Other offsets: writes ignored, reads return 0.
- LENGTH, THRESH and trig_en are shadow registers, copied into working registers only on start.
- States and codes: IDLE 0, ARMED 1, CAPTURE 2, DRAIN 3, READY 4.
  - IDLE --start, trig_en=1--> ARMED; IDLE --start, trig_en=0--> CAPTURE.
  - ARMED: on `advance` with |`sample_in`| >= THRESH -> CAPTURE. That sample is written at address 0.
  - CAPTURE: each `advance` drives `ram_we`=1, `ram_addr`=wr_ptr, `ram_din`=`sample_in` for one cycle, then wr_ptr++. The write at wr_ptr = len-1 moves to DRAIN.
  - DRAIN: exactly one cycle, -> READY.
  - READY: each DATA read returns sext(`ram_dout`) and increments rd_ptr. The read with rd_ptr = len-1 returns the last sample, sets `done`, and moves to IDLE.
- Start clears wr_ptr, rd_ptr and `done`.
- `ram_addr` = wr_ptr in CAPTURE, otherwise rd_ptr.
- Magnitude of the most negative sample saturates to 2**(`SAMPLE_W`-1).
- DATA read outside READY returns sext of the last `sample_in` latched on `advance` (passthrough). No pointer change.
- Start in any non-IDLE state = abort + start, in the same cycle.
- Abort in any state -> IDLE: `ram_we` low next cycle, `done` unchanged.
- Start and abort in the same write: abort wins.

## Timing
- Reset values: `readdata`=0, `ram_we`=0, `ram_addr`=0, `ram_din`=0, `busy`=0, `done`=0, state IDLE, all pointers and shadow registers 0.
- CTRL start takes effect on the next cycle. An `advance` in the same cycle as the start write is not captured or trigger-checked.
- `advance` coincident with a host access: both are processed. In CAPTURE, host traffic never touches the BRAM port.
- DRAIN guarantees `ram_dout` = mem[0] by the first READY cycle.
- Successive DATA reads in READY must be ≥2 cycles apart. A read 1 cycle after the previous one returns the previous sample again but still advances rd_ptr. The bench checks this defined behaviour.
- `readdata` latency is 1 cycle for every offset.
- Reset mid-operation: return to IDLE with reset values on the next edge. BRAM contents are don't-care.

## Structure
- Shared package `aud_pkg`:
  - state enum `cap_state_t`
  - register offset constants `REG_CTRL`…`REG_DATA`
  - `SAMPLE_W`, `ADDR_W`, `DEPTH` defaults
  - sign-extension function `sext32`
- One sub-module, `aud_trigger_detect`: combinational |sample| >= threshold compare, including negative saturation.
- The BRAM stays external: the existing `bram` module, with `ram_enable` tied high.

## Test plan
- LENGTH=4, start with trig_en=0, 4 `advance` strobes with samples 0x000001, 0x7FFFFF, 0x800000, 0xFFFFFE:
  - STATUS state goes 2, then 3, then 4.
  - 4 spaced DATA reads return 0x00000001, 0x007FFFFF, 0xFF800000, 0xFFFFFFFE.
  - `done`=1, state 0.
- trig_en=1, THRESH=0x001000, samples 0x000FFF, 0xFFF001 (-4095), 0xFFF000 (-4096), 0x000005:
  - stays ARMED for the first two samples.
  - capture begins at 0xFFF000, stored at address 0.
- LENGTH=0 with a full run: exactly 2048 writes; the 2048th DATA read sets `done`; STATUS pointer wraps to 0.
- Abort after 3 of 8 captures: `ram_we` stays low on later `advance` strobes; `busy`=0; DATA read returns the passthrough sample.
- Start again while in READY after 2 of 4 reads: `done`=0, pointers 0, a fresh capture of new samples is read back.
- `reset` asserted mid-CAPTURE with `advance` active: next cycle all outputs at reset values and no further `ram_we` pulses.

Source files
------------

// File: rtl/aud_pkg.sv
// Shared definitions for the audio capture sequencer: sizes, states, register map.
// No logic beyond a pure sign-extension helper.
// Imported by the capture controller and its testbench.
package aud_pkg;

    localparam int SAMPLE_W = 24;
    localparam int ADDR_W   = 11;
    localparam int DEPTH    = 2048;

    // State codes are visible to the host through STATUS[2:0]
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ARMED   = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_DRAIN   = 3'd3,
        ST_READY   = 3'd4
    } cap_state_t;

    localparam logic [15:0] REG_CTRL   = 16'd0;
    localparam logic [15:0] REG_LENGTH = 16'd1;
    localparam logic [15:0] REG_THRESH = 16'd2;
    localparam logic [15:0] REG_STATUS = 16'd3;
    localparam logic [15:0] REG_DATA   = 16'd4;

    function automatic logic [31:0] sext32(input logic [SAMPLE_W-1:0] s);
        return {{(32-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

endpackage

// File: rtl/aud_trigger_detect.sv
// Amplitude trigger: |sample| >= threshold, threshold treated as unsigned magnitude.
// Purely combinational, zero latency.
// No flow control; evaluated every cycle, qualified by the caller.
module aud_trigger_detect #(
    parameter int SAMPLE_W = 24
) (
    input  logic [SAMPLE_W-1:0] sample,
    input  logic [SAMPLE_W-1:0] thresh,
    output logic                hit
);

    logic [SAMPLE_W-1:0] mag;

    // Two's complement negate as unsigned; the most negative value maps to
    // 2**(SAMPLE_W-1), which is exactly the saturated magnitude.
    always_comb begin
        mag = sample[SAMPLE_W-1] ? (~sample + SAMPLE_W'(1)) : sample;
        hit = (mag >= thresh);
    end

endmodule

// File: rtl/aud_capture_ctrl.sv
// Audio capture sequencer: arm/trigger, capture N samples to BRAM, serve them via DATA reads.
// readdata 1 cycle after read; BRAM write port is combinational from advance.
// No backpressure: advance strobes are never stalled; DATA reads in READY need >=2 cycle spacing.
module aud_capture_ctrl #(
    parameter int SAMPLE_W = aud_pkg::SAMPLE_W,
    parameter int ADDR_W   = aud_pkg::ADDR_W,
    parameter int DEPTH    = aud_pkg::DEPTH
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                advance,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                chipselect,
    input  logic                write,
    input  logic                read,
    input  logic [15:0]         address,
    input  logic [31:0]         writedata,
    output logic [31:0]         readdata,
    output logic [ADDR_W-1:0]   ram_addr,
    output logic                ram_we,
    output logic [SAMPLE_W-1:0] ram_din,
    input  logic [SAMPLE_W-1:0] ram_dout,
    output logic                busy,
    output logic                done
);

    import aud_pkg::*;

    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    cap_state_t          state;
    logic [ADDR_W-1:0]   wr_ptr;
    logic [ADDR_W-1:0]   rd_ptr;
    logic [ADDR_W-1:0]   last_idx;      // working copy: clamped LENGTH minus one
    logic [ADDR_W:0]     len_sh;
    logic [SAMPLE_W-1:0] thresh_sh;
    logic [SAMPLE_W-1:0] thresh_w;
    logic [SAMPLE_W-1:0] last_sample;   // passthrough value for DATA reads outside READY

    logic                host_wr, host_rd;
    logic                ctrl_wr, start, abort;
    logic                trig_hit;
    logic                cap_wr;
    logic [ADDR_W-1:0]   last_idx_next;
    logic [ADDR_W-1:0]   cur_ptr;
    logic [31:0]         status_word;
    logic                unused_wdata;

    assign unused_wdata = ^writedata[31:SAMPLE_W];

    aud_trigger_detect #(.SAMPLE_W(SAMPLE_W)) u_trig (
        .sample (sample_in),
        .thresh (thresh_w),
        .hit    (trig_hit)
    );

    // Host decode, capture qualification and BRAM port steering
    always_comb begin
        host_wr = chipselect & write;
        host_rd = chipselect & read;
        ctrl_wr = host_wr && (address == REG_CTRL);
        abort   = ctrl_wr & writedata[1];
        start   = ctrl_wr & writedata[0] & ~writedata[1];

        // A LENGTH of DEPTH has zero low bits, so the subtraction wraps to all-ones as wanted
        if ((len_sh == '0) || (len_sh > DEPTH_L))
            last_idx_next = '1;
        else
            last_idx_next = len_sh[ADDR_W-1:0] - ADDR_W'(1);

        // An advance coincident with a CTRL command or reset is never captured
        cap_wr = advance && !reset && !start && !abort &&
                 ((state == ST_CAPTURE) || ((state == ST_ARMED) && trig_hit));

        ram_we   = cap_wr;
        ram_din  = cap_wr ? sample_in : '0;
        ram_addr = ((state == ST_CAPTURE) || (state == ST_ARMED)) ? wr_ptr : rd_ptr;
        cur_ptr  = ram_addr;
        busy     = (state != ST_IDLE);

        status_word                 = '0;
        status_word[2:0]            = state;
        status_word[3]              = done;
        status_word[ADDR_W+15:16]   = cur_ptr;
    end

    // Sequencer, shadow registers and registered read data
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            last_idx    <= '0;
            len_sh      <= '0;
            thresh_sh   <= '0;
            thresh_w    <= '0;
            last_sample <= '0;
            done        <= 1'b0;
            readdata    <= '0;
        end else begin
            if (host_wr && (address == REG_LENGTH))
                len_sh <= writedata[ADDR_W:0];
            if (host_wr && (address == REG_THRESH))
                thresh_sh <= writedata[SAMPLE_W-1:0];
            if (advance)
                last_sample <= sample_in;

            readdata <= '0;
            if (host_rd) begin
                case (address)
                    REG_STATUS: readdata <= status_word;
                    REG_DATA:   readdata <= (state == ST_READY) ? sext32(ram_dout)
                                                                : sext32(last_sample);
                    default:    readdata <= '0;
                endcase
            end

            if (abort) begin
                state <= ST_IDLE;
            end else if (start) begin
                state    <= writedata[2] ? ST_ARMED : ST_CAPTURE;
                wr_ptr   <= '0;
                rd_ptr   <= '0;
                done     <= 1'b0;
                last_idx <= last_idx_next;
                thresh_w <= thresh_sh;
            end else begin
                case (state)
                    ST_ARMED, ST_CAPTURE: begin
                        if (cap_wr) begin
                            wr_ptr <= wr_ptr + ADDR_W'(1);
                            state  <= (wr_ptr == last_idx) ? ST_DRAIN : ST_CAPTURE;
                        end
                    end
                    ST_DRAIN: state <= ST_READY;
                    ST_READY: begin
                        if (host_rd && (address == REG_DATA)) begin
                            rd_ptr <= rd_ptr + ADDR_W'(1);
                            if (rd_ptr == last_idx) begin
                                done  <= 1'b1;
                                state <= ST_IDLE;
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_aud_capture_ctrl.sv
// Self-checking bench for aud_capture_ctrl with a behavioural BRAM and sample-list model.
// Inputs driven on the falling edge, outputs sampled on the falling edge or 1ns after driving.
// Randomized capture runs are checked against expected sample queues built from the rules.
module tb_aud_capture_ctrl;

    localparam int SW = 24;
    localparam int AW = 11;
    localparam int D  = 2048;

    localparam logic [15:0] A_CTRL = 16'd0, A_LEN = 16'd1, A_THR = 16'd2, A_STAT = 16'd3, A_DATA = 16'd4;

    logic          clk = 1'b0;
    logic          reset, advance, chipselect, write, read;
    logic [SW-1:0] sample_in, ram_din, ram_dout;
    logic [15:0]   address;
    logic [31:0]   writedata, readdata;
    logic [AW-1:0] ram_addr;
    logic          ram_we, busy, done;

    always #5 clk = ~clk;

    aud_capture_ctrl dut (
        .clk(clk), .reset(reset), .advance(advance), .sample_in(sample_in),
        .chipselect(chipselect), .write(write), .read(read), .address(address),
        .writedata(writedata), .readdata(readdata), .ram_addr(ram_addr),
        .ram_we(ram_we), .ram_din(ram_din), .ram_dout(ram_dout),
        .busy(busy), .done(done)
    );

    // External BRAM stand-in: 1-cycle read latency, enable tied high
    logic [SW-1:0] mem [0:D-1];
    int n_wr = 0;
    int wr_log[$];
    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_din;
            n_wr <= n_wr + 1;
            wr_log.push_back(int'(ram_addr));
        end
        ram_dout <= mem[ram_addr];
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic int mag(input logic [SW-1:0] s);
        int v;
        v = $signed(s);
        return (v < 0) ? -v : v;
    endfunction

    function automatic logic [31:0] sx(input logic [SW-1:0] s);
        int v;
        v = $signed(s);
        return 32'(v);
    endfunction

    task automatic bus_wr(input logic [15:0] a, input logic [31:0] d);
        chipselect = 1'b1; write = 1'b1; address = a; writedata = d;
        @(negedge clk);
        chipselect = 1'b0; write = 1'b0;
    endtask

    task automatic bus_rd(input logic [15:0] a, output logic [31:0] d);
        chipselect = 1'b1; read = 1'b1; address = a;
        @(negedge clk);
        chipselect = 1'b0; read = 1'b0;
        d = readdata;
    endtask

    task automatic adv(input logic [SW-1:0] s, output logic we);
        advance = 1'b1; sample_in = s;
        #1 we = ram_we;
        @(negedge clk);
        advance = 1'b0;
    endtask

    function automatic logic [SW-1:0] pick(input logic [SW-1:0] thr);
        case ($urandom_range(0, 7))
            0: return 24'h800000;
            1: return 24'h7FFFFF;
            2: return thr;
            3: return ~thr + 24'd1;
            4: return (thr == 0) ? 24'd0 : thr - 24'd1;
            default: return 24'($urandom);
        endcase
    endfunction

    // Full capture + readback run checked against an expected-sample queue
    task automatic do_run(input int len_reg, input bit trig, input logic [SW-1:0] thr, input string tag);
        logic [SW-1:0] exp_q[$];
        logic [SW-1:0] s;
        logic [31:0]   rd;
        logic          we;
        bit            trg;
        int            eff, steps;
        eff = (len_reg == 0 || len_reg > D) ? D : len_reg;
        bus_wr(A_LEN, 32'(len_reg));
        bus_wr(A_THR, {8'h0, thr});
        bus_wr(A_CTRL, trig ? 32'h5 : 32'h1);
        trg = !trig;
        steps = 0;
        while (exp_q.size() < eff && steps < eff + 300) begin
            s = pick(thr);
            if (!trg && mag(s) >= int'(thr)) trg = 1;
            if (trg) exp_q.push_back(s);
            adv(s, we);
            if (eff <= 64) check({tag, "_we"}, {31'd0, we}, {31'd0, trg});
            steps++;
        end
        check({tag, "_fill"}, exp_q.size(), eff);
        bus_rd(A_STAT, rd);
        check({tag, "_drain"}, rd[2:0], 3);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == exp_q.size() - 1) check({tag, "_done_pre"}, {31'd0, done}, 0);
            bus_rd(A_DATA, rd);
            check({tag, "_data"}, rd, sx(exp_q[i]));
            repeat ($urandom_range(1, 2)) @(negedge clk);
        end
        bus_rd(A_STAT, rd);
        check({tag, "_end_stat"}, rd, {4'd0, 12'(eff % D), 12'd0, 1'b1, 3'd0});
    endtask

    logic [31:0]   rd;
    logic          we;
    int            wc;
    logic [SW-1:0] a[4];
    logic [SW-1:0] b[4];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        reset = 1'b1; advance = 1'b0; chipselect = 1'b0; write = 1'b0; read = 1'b0;
        address = '0; writedata = '0; sample_in = '0;
        repeat (3) @(negedge clk);
        check("rst_readdata", readdata, 0);
        check("rst_ram_we", {31'd0, ram_we}, 0);
        check("rst_ram_addr", 32'(ram_addr), 0);
        check("rst_ram_din", 32'(ram_din), 0);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        reset = 1'b0;
        bus_rd(A_STAT, rd);
        check("rst_status", rd, 0);
        bus_rd(A_DATA, rd);
        check("rst_data", rd, 0);

        // Directed: LENGTH=4, no trigger
        bus_wr(A_LEN, 4);
        bus_wr(A_CTRL, 1);
        bus_rd(A_STAT, rd);
        check("t1_state_cap", rd[2:0], 2);
        adv(24'h000001, we); adv(24'h7FFFFF, we); adv(24'h800000, we);
        bus_rd(A_STAT, rd);
        check("t1_state_cap3", rd[2:0], 2);
        adv(24'hFFFFFE, we);
        bus_rd(A_STAT, rd);
        check("t1_state_drain", rd[2:0], 3);
        bus_rd(A_STAT, rd);
        check("t1_state_ready", rd[2:0], 4);
        @(negedge clk);
        bus_rd(A_DATA, rd); check("t1_d0", rd, 32'h00000001); @(negedge clk);
        bus_rd(A_DATA, rd); check("t1_d1", rd, 32'h007FFFFF); @(negedge clk);
        bus_rd(A_DATA, rd); check("t1_d2", rd, 32'hFF800000); @(negedge clk);
        bus_rd(A_DATA, rd); check("t1_d3", rd, 32'hFFFFFFFE); @(negedge clk);
        bus_rd(A_STAT, rd);
        check("t1_status_end", rd, 32'h00040008);
        check("t1_busy", {31'd0, busy}, 0);

        // Directed trigger: THRESH=0x1000
        bus_wr(A_LEN, 4);
        bus_wr(A_THR, 32'h1000);
        bus_wr(A_CTRL, 5);
        adv(24'h000FFF, we); check("t2_we0", {31'd0, we}, 0);
        adv(24'hFFF001, we); check("t2_we1", {31'd0, we}, 0);
        bus_rd(A_STAT, rd);
        check("t2_armed", rd[2:0], 1);
        wc = wr_log.size();
        adv(24'hFFF000, we); check("t2_we2", {31'd0, we}, 1);
        check("t2_addr0", (wr_log.size() > wc) ? wr_log[wc] : -1, 0);
        adv(24'h000005, we); adv(24'h123456, we); adv(24'hABCDEF, we);
        @(negedge clk);
        bus_rd(A_DATA, rd); check("t2_d0", rd, 32'hFFFFF000); @(negedge clk);
        bus_rd(A_DATA, rd); check("t2_d1", rd, 32'h00000005); @(negedge clk);
        bus_rd(A_DATA, rd); check("t2_d2", rd, 32'h00123456); @(negedge clk);
        bus_rd(A_DATA, rd); check("t2_d3", rd, 32'hFFABCDEF); @(negedge clk);
        check("t2_done", {31'd0, done}, 1);

        // Randomized runs
        for (int it = 0; it < 6; it++)
            do_run($urandom_range(1, 10), 1'($urandom_range(0, 1)), 24'($urandom_range(0, 24'h400000)), "rnd");

        // LENGTH=0 clamps to the full depth
        wc = n_wr;
        do_run(0, 1'b0, 24'd0, "full");
        check("full_writes", n_wr - wc, D);

        // Abort after 3 of 8 captures
        bus_wr(A_LEN, 8);
        bus_wr(A_CTRL, 1);
        adv(24'h111111, we); adv(24'h222222, we); adv(24'h333333, we);
        bus_wr(A_CTRL, 2);
        wc = n_wr;
        adv(24'h444444, we); check("ab_we0", {31'd0, we}, 0);
        adv(24'hC55555, we); check("ab_we1", {31'd0, we}, 0);
        check("ab_writes", n_wr - wc, 0);
        check("ab_busy", {31'd0, busy}, 0);
        check("ab_done", {31'd0, done}, 0);
        bus_rd(A_DATA, rd);
        check("ab_pass", rd, 32'hFFC55555);
        bus_wr(A_CTRL, 3);
        check("ab_wins_busy", {31'd0, busy}, 0);

        // Restart while in READY after 2 of 4 reads
        for (int i = 0; i < 4; i++) begin a[i] = 24'($urandom); b[i] = 24'($urandom); end
        bus_wr(A_LEN, 4);
        bus_wr(A_CTRL, 1);
        for (int i = 0; i < 4; i++) adv(a[i], we);
        repeat (2) @(negedge clk);
        bus_rd(A_DATA, rd); check("rs_a0", rd, sx(a[0])); @(negedge clk);
        bus_rd(A_DATA, rd); check("rs_a1", rd, sx(a[1])); @(negedge clk);
        bus_wr(A_CTRL, 1);
        check("rs_done", {31'd0, done}, 0);
        bus_rd(A_STAT, rd);
        check("rs_status", rd, 32'h00000002);
        for (int i = 0; i < 4; i++) adv(b[i], we);
        repeat (2) @(negedge clk);
        bus_rd(A_DATA, rd); check("rs_b0", rd, sx(b[0]));
        bus_rd(A_DATA, rd); check("rs_b0_again", rd, sx(b[0])); @(negedge clk);
        bus_rd(A_DATA, rd); check("rs_b2", rd, sx(b[2])); @(negedge clk);
        bus_rd(A_DATA, rd); check("rs_b3", rd, sx(b[3]));
        check("rs_done_end", {31'd0, done}, 1);
        bus_rd(A_STAT, rd);
        check("rs_state_end", rd[2:0], 0);

        // Reset in the middle of a capture with advance active
        bus_wr(A_LEN, 8);
        bus_wr(A_CTRL, 1);
        adv(24'h0A0A0A, we); adv(24'h0B0B0B, we);
        advance = 1'b1; sample_in = 24'h0C0C0C; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0; sample_in = 24'h0D0D0D;
        wc = n_wr;
        #1;
        check("mr_ram_we", {31'd0, ram_we}, 0);
        check("mr_ram_addr", 32'(ram_addr), 0);
        check("mr_ram_din", 32'(ram_din), 0);
        check("mr_busy", {31'd0, busy}, 0);
        check("mr_done", {31'd0, done}, 0);
        check("mr_readdata", readdata, 0);
        @(negedge clk);
        advance = 1'b0;
        adv(24'h0E0E0E, we); adv(24'h0F0F0F, we);
        check("mr_no_writes", n_wr - wc, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
